// File: rtl/sram_arbiter_if.sv
// Bundle of the two sbus master ports and the shared single-port SRAM port.
// The arbiter uses the slave view; the bus-side environment uses the master view.
interface sram_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned BE_W = DATA_W / 8;

  logic              m0_req;
  logic [BE_W-1:0]   m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_ack;
  logic [DATA_W-1:0] m0_rdata;

  logic              m1_req;
  logic [BE_W-1:0]   m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_ack;
  logic [DATA_W-1:0] m1_rdata;

  logic              sram_en;
  logic [BE_W-1:0]   sram_we;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata;

  logic [15:0]       conflict_cnt;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    input  sram_rdata,
    output m0_ack, m0_rdata, m1_ack, m1_rdata,
    output sram_en, sram_we, sram_addr, sram_wdata,
    output conflict_cnt
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    output sram_rdata,
    input  m0_ack, m0_rdata, m1_ack, m1_rdata,
    input  sram_en, sram_we, sram_addr, sram_wdata,
    input  conflict_cnt
  );
endinterface

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous SRAM between the
// instruction bus (m0) and data bus (m1); one issue per cycle, ack one cycle later.
module sram_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic          clk,
  input  logic          rst,
  sram_arbiter_if.slave bus
);
  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  logic              r_busy;
  logic              r_owner;
  logic              r_last;
  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_elig0;
  logic              w_elig1;
  logic              w_issue;
  logic              w_grant;
  logic              w_conflict;
  logic              w_ack0;
  logic              w_ack1;
  logic [BE_W-1:0]   w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;

  // A master whose access is completing this cycle cannot be reissued yet.
  always_comb begin
    w_elig0    = bus.m0_req & ~(r_busy & (r_owner == M0));
    w_elig1    = bus.m1_req & ~(r_busy & (r_owner == M1));
    w_issue    = ~rst & (w_elig0 | w_elig1);
    w_conflict = ~rst & w_elig0 & w_elig1;
    w_grant    = M0;
    if (w_elig0 & w_elig1) begin
      w_grant = ~r_last;
    end else if (w_elig1) begin
      w_grant = M1;
    end
  end

  // SRAM port mux; idle and reset drive zeros.
  always_comb begin
    w_we    = '0;
    w_addr  = '0;
    w_wdata = '0;
    if (w_issue) begin
      if (w_grant == M1) begin
        w_we    = bus.m1_we;
        w_addr  = bus.m1_addr;
        w_wdata = bus.m1_wdata;
      end else begin
        w_we    = bus.m0_we;
        w_addr  = bus.m0_addr;
        w_wdata = bus.m0_wdata;
      end
    end
  end

  always_comb begin
    w_ack0 = r_busy & (r_owner == M0);
    w_ack1 = r_busy & (r_owner == M1);
  end

  assign bus.sram_en      = w_issue;
  assign bus.sram_we      = w_we;
  assign bus.sram_addr    = w_addr;
  assign bus.sram_wdata   = w_wdata;
  assign bus.m0_ack       = w_ack0;
  assign bus.m1_ack       = w_ack1;
  assign bus.m0_rdata     = w_ack0 ? bus.sram_rdata : r_rdata0;
  assign bus.m1_rdata     = w_ack1 ? bus.sram_rdata : r_rdata1;
  assign bus.conflict_cnt = r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy   <= 1'b0;
      r_owner  <= M0;
      r_last   <= M0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
      r_cnt    <= '0;
    end else begin
      r_busy <= w_issue;
      if (w_issue) begin
        r_owner <= w_grant;
        r_last  <= w_grant;
      end
      if (w_ack0) begin
        r_rdata0 <= bus.sram_rdata;
      end
      if (w_ack1) begin
        r_rdata1 <= bus.sram_rdata;
      end
      // Saturating: a loser of the tie counts one conflict cycle.
      if (w_conflict && (r_cnt != CNT_MAX)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: transaction-level reference model predicts
// SRAM issues, acks and read data; a separate monitor compares every cycle.
`timescale 1ns/1ps
module tb_sram_arbiter;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = DATA_W / 8;

  typedef struct {
    logic [BE_W-1:0]   we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    int                gap;
  } txn_t;

  typedef struct {
    int                cyc;
    logic [BE_W-1:0]   we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } iss_t;

  typedef struct {
    int                cyc;
    int                m;
    logic [DATA_W-1:0] rdata;
  } ack_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  sram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
  sram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- master drivers ----------------
  logic              d_req   [2] = '{1'b0, 1'b0};
  logic [BE_W-1:0]   d_we    [2] = '{'0, '0};
  logic [ADDR_W-1:0] d_addr  [2] = '{'0, '0};
  logic [DATA_W-1:0] d_wdata [2] = '{'0, '0};
  int                cur_id  [2] = '{0, 0};
  int                req_start [2] = '{0, 0};
  txn_t txq0[$];
  txn_t txq1[$];

  assign bus.m0_req   = d_req[0];
  assign bus.m0_we    = d_we[0];
  assign bus.m0_addr  = d_addr[0];
  assign bus.m0_wdata = d_wdata[0];
  assign bus.m1_req   = d_req[1];
  assign bus.m1_we    = d_we[1];
  assign bus.m1_addr  = d_addr[1];
  assign bus.m1_wdata = d_wdata[1];

  task automatic push(input int m, input logic [BE_W-1:0] we, input logic [ADDR_W-1:0] addr,
                      input logic [DATA_W-1:0] wdata, input int gap);
    txn_t t;
    t.we = we; t.addr = addr; t.wdata = wdata; t.gap = gap;
    if (m == 0) txq0.push_back(t);
    else        txq1.push_back(t);
  endtask

  task automatic drive(input int m);
    logic ackd;
    int   wait_cnt;
    int   qs;
    txn_t t;
    wait_cnt = 0;
    forever begin
      @(negedge clk); #3;
      ackd = (m == 0) ? bus.m0_ack : bus.m1_ack;
      @(posedge clk); #1;
      if (rst) begin
        d_req[m] = 1'b0;
        wait_cnt = 0;
      end else begin
        if (d_req[m] && ackd) d_req[m] = 1'b0;
        qs = (m == 0) ? txq0.size() : txq1.size();
        if (!d_req[m] && qs > 0) begin
          t = (m == 0) ? txq0[0] : txq1[0];
          if (wait_cnt < t.gap) begin
            wait_cnt++;
          end else begin
            if (m == 0) void'(txq0.pop_front());
            else        void'(txq1.pop_front());
            d_we[m] = t.we; d_addr[m] = t.addr; d_wdata[m] = t.wdata;
            d_req[m] = 1'b1;
            cur_id[m]++;
            req_start[m] = cyc;
            wait_cnt = 0;
          end
        end
      end
    end
  endtask

  initial drive(0);
  initial drive(1);

  // ---------------- memories ----------------
  logic [DATA_W-1:0] sram_mem [logic [ADDR_W-1:0]];
  logic [DATA_W-1:0] ref_mem  [logic [ADDR_W-1:0]];
  logic [DATA_W-1:0] sram_q = '0;
  assign bus.sram_rdata = sram_q;

  function automatic logic [DATA_W-1:0] init_word(input logic [ADDR_W-1:0] a);
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old,
                                              input logic [DATA_W-1:0] wd,
                                              input logic [BE_W-1:0] we);
    logic [DATA_W-1:0] r;
    r = old;
    for (int b = 0; b < int'(BE_W); b++)
      if (we[b]) r[b*8 +: 8] = wd[b*8 +: 8];
    return r;
  endfunction

  // Behavioural SRAM: read-before-write, data one cycle after enable.
  always @(posedge clk) begin
    logic [DATA_W-1:0] old;
    if (bus.sram_en) begin
      old = sram_mem.exists(bus.sram_addr) ? sram_mem[bus.sram_addr] : init_word(bus.sram_addr);
      sram_q <= old;
      sram_mem[bus.sram_addr] = merge(old, bus.sram_wdata, bus.sram_we);
    end
  end

  // ---------------- reference model ----------------
  int          served_id [2] = '{0, 0};
  int          last_srv = 0;
  logic [15:0] m_cnt = '0;
  logic [15:0] exp_cnt_now = '0;
  int          preset_seq = 0;
  int          preset_seen = 0;
  logic [15:0] preset_val = '0;
  iss_t        exp_iss[$];
  ack_t        exp_ack[$];

  always @(negedge clk) begin
    logic w0, w1;
    int   win;
    logic [DATA_W-1:0] old;
    iss_t  ie;
    ack_t  ae;
    if (preset_seq != preset_seen) begin
      m_cnt = preset_val;
      preset_seen = preset_seq;
    end
    exp_cnt_now = m_cnt;
    if (rst) begin
      served_id[0] = cur_id[0];
      served_id[1] = cur_id[1];
      last_srv = 0;
      m_cnt = '0;
      exp_cnt_now = '0;
      exp_iss.delete();
      exp_ack.delete();
    end else begin
      // A transaction waits until it has been served once.
      w0 = d_req[0] && (served_id[0] != cur_id[0]);
      w1 = d_req[1] && (served_id[1] != cur_id[1]);
      if (w0 || w1) begin
        if (w0 && w1) begin
          win = 1 - last_srv;
          if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end else begin
          win = w1 ? 1 : 0;
        end
        old = ref_mem.exists(d_addr[win]) ? ref_mem[d_addr[win]] : init_word(d_addr[win]);
        ref_mem[d_addr[win]] = merge(old, d_wdata[win], d_we[win]);
        ie.cyc = cyc; ie.we = d_we[win]; ie.addr = d_addr[win]; ie.wdata = d_wdata[win];
        exp_iss.push_back(ie);
        ae.cyc = cyc + 1; ae.m = win; ae.rdata = old;
        exp_ack.push_back(ae);
        served_id[win] = cur_id[win];
        last_srv = win;
      end
    end
  end

  // ---------------- monitor ----------------
  logic [DATA_W-1:0] held [2] = '{'0, '0};
  logic prev_req [2] = '{1'b0, 1'b0};
  logic prev_ack [2] = '{1'b0, 1'b0};

  always @(negedge clk) begin
    logic exp_en, exp_a;
    iss_t ie;
    ack_t ae;
    logic [DATA_W-1:0] rd [2];
    logic              ak [2];
    logic              rq [2];
    #2;
    rd[0] = bus.m0_rdata; rd[1] = bus.m1_rdata;
    ak[0] = bus.m0_ack;   ak[1] = bus.m1_ack;
    rq[0] = bus.m0_req;   rq[1] = bus.m1_req;
    if (rst) begin
      held[0] = '0; held[1] = '0;
      prev_req[0] = 1'b0; prev_req[1] = 1'b0;
    end else begin
      for (int m = 0; m < 2; m++) begin
        if (prev_req[m] && !prev_ack[m])
          assert (rq[m]) else $error("FAIL protocol: m%0d request withdrawn before ack", m);
        prev_req[m] = rq[m];
        prev_ack[m] = ak[m];
      end
      check("conflict_cnt", 64'(bus.conflict_cnt), 64'(exp_cnt_now));

      exp_en = (exp_iss.size() > 0) && (exp_iss[0].cyc == cyc);
      check("sram_en", 64'(bus.sram_en), 64'(exp_en));
      if (exp_en) begin
        ie = exp_iss.pop_front();
        if (bus.sram_en) begin
          check("sram_addr",  64'(bus.sram_addr),  64'(ie.addr));
          check("sram_we",    64'(bus.sram_we),    64'(ie.we));
          check("sram_wdata", 64'(bus.sram_wdata), 64'(ie.wdata));
        end
      end

      exp_a = (exp_ack.size() > 0) && (exp_ack[0].cyc == cyc);
      ae.m = -1;
      ae.rdata = '0;
      if (exp_a) ae = exp_ack.pop_front();
      for (int m = 0; m < 2; m++) begin
        check($sformatf("m%0d_ack", m), 64'(ak[m]), 64'(exp_a && (ae.m == m)));
        if (exp_a && ae.m == m) begin
          check($sformatf("m%0d_rdata_ack", m), 64'(rd[m]), 64'(ae.rdata));
          check($sformatf("m%0d_wait_le2", m), 64'((cyc - req_start[m]) <= 2), 64'(1));
          held[m] = ae.rdata;
        end else begin
          check($sformatf("m%0d_rdata_held", m), 64'(rd[m]), 64'(held[m]));
        end
      end
    end
  end

  // ---------------- directed / random sequences ----------------
  task automatic check_reset_outputs(input string tag);
    check({tag, "_sram_en"},    64'(bus.sram_en),      64'(0));
    check({tag, "_sram_we"},    64'(bus.sram_we),      64'(0));
    check({tag, "_sram_addr"},  64'(bus.sram_addr),    64'(0));
    check({tag, "_sram_wdata"}, 64'(bus.sram_wdata),   64'(0));
    check({tag, "_m0_ack"},     64'(bus.m0_ack),       64'(0));
    check({tag, "_m1_ack"},     64'(bus.m1_ack),       64'(0));
    check({tag, "_m0_rdata"},   64'(bus.m0_rdata),     64'(0));
    check({tag, "_m1_rdata"},   64'(bus.m1_rdata),     64'(0));
    check({tag, "_cnt"},        64'(bus.conflict_cnt), 64'(0));
  endtask

  task automatic wait_idle(input int budget);
    logic idle;
    idle = 1'b0;
    for (int i = 0; i < budget && !idle; i++) begin
      @(negedge clk); #4;
      idle = (txq0.size() == 0) && (txq1.size() == 0) && !d_req[0] && !d_req[1]
             && (exp_ack.size() == 0);
    end
    if (!idle) check("idle_timeout", 64'(idle), 64'(1));
  endtask

  task automatic wait_any_ack(input int budget, output logic a0, output logic a1);
    a0 = 1'b0; a1 = 1'b0;
    for (int i = 0; i < budget && !(a0 || a1); i++) begin
      @(negedge clk); #4;
      a0 = bus.m0_ack; a1 = bus.m1_ack;
    end
    if (!(a0 || a1)) check("ack_timeout", 64'(a0 || a1), 64'(1));
  endtask

  task automatic tie_test(input string tag);
    logic a0, a1;
    push(0, '0, 32'h0000_0200, '0, 0);
    push(1, '0, 32'h0000_0204, '0, 0);
    wait_any_ack(20, a0, a1);
    check({tag, "_first_m1"}, 64'(a1), 64'(1));
    check({tag, "_first_not_m0"}, 64'(a0), 64'(0));
    @(negedge clk); #4;
    check({tag, "_second_m0"}, 64'(bus.m0_ack), 64'(1));
    wait_idle(50);
  endtask

  initial begin
    logic a0, a1;
    int   acks;
    logic seen;
    sram_mem[32'h100] = 32'hDEAD_BEEF; ref_mem[32'h100] = 32'hDEAD_BEEF;
    sram_mem[32'h040] = 32'h1122_3344; ref_mem[32'h040] = 32'h1122_3344;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); #4;
    check_reset_outputs("reset");
    @(posedge clk); #2;
    rst = 1'b0;

    // Single read
    push(0, '0, 32'h0000_0100, '0, 0);
    wait_idle(50);
    check("single_rd_held", 64'(bus.m0_rdata), 64'(32'hDEAD_BEEF));
    check("single_rd_cnt", 64'(bus.conflict_cnt), 64'(0));

    // Tie after reset goes to m1
    tie_test("tie");
    check("tie_cnt", 64'(bus.conflict_cnt), 64'(1));

    // Continuous contention: one ack per cycle
    for (int i = 0; i < 10; i++) begin
      push(0, '0, 32'h300 + 32'(i * 4), '0, 0);
      push(1, '0, 32'h380 + 32'(i * 4), '0, 0);
    end
    wait_any_ack(20, a0, a1);
    acks = (a0 || a1) ? 1 : 0;
    for (int i = 0; i < 19; i++) begin
      @(negedge clk); #4;
      if (bus.m0_ack || bus.m1_ack) acks++;
    end
    check("contention_acks", 64'(acks), 64'(20));
    wait_idle(50);

    // Write then read of the same word
    push(1, 4'b1100, 32'h0000_0040, 32'hCAFE_0000, 0);
    @(posedge clk); #2;
    push(0, '0, 32'h0000_0040, '0, 0);
    wait_idle(50);
    check("wr_rd_upper", 64'(bus.m0_rdata), 64'(32'hCAFE_3344));

    // Reset mid-access, after m1 was last served
    push(1, '0, 32'h0000_0044, '0, 0);
    wait_idle(50);
    push(1, '0, 32'h0000_0048, '0, 0);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk); #4;
      seen = bus.sram_en;
    end
    check("rst_mid_issue_seen", 64'(seen), 64'(1));
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #4;
      check("rst_mid_no_ack", 64'(bus.m1_ack), 64'(0));
    end
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk); #4;
    check_reset_outputs("post_rst");
    tie_test("post_rst_tie");

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      for (int m = 0; m < 2; m++) begin
        push(m, ($urandom_range(0, 1) == 0) ? '0 : BE_W'($urandom_range(1, 15)),
             32'h400 + 32'($urandom_range(0, 15) * 4), $urandom, int'($urandom_range(0, 3)));
      end
    end
    wait_idle(6000);

    // Saturation: preload near the top, then force conflicts
    @(posedge clk); #1;
    force dut.r_cnt = 16'hFFF8;
    preset_val = 16'hFFF8;
    preset_seq++;
    #1 release dut.r_cnt;
    for (int i = 0; i < 12; i++) begin
      push(0, '0, 32'h500, '0, 0);
      push(1, '0, 32'h504, '0, 0);
      wait_idle(50);
    end
    check("cnt_saturated", 64'(bus.conflict_cnt), 64'(16'hFFFF));
    check("scoreboard_drained", 64'(exp_ack.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
